// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the PE multiply/accumulate datapath.
// Holds width constants, special encodings, operand classes and the unpack helper.
// Used by floating_point_multiplier and floating_point_adder alike.
package fp16_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int EXP_WIDTH  = 5;
   localparam int MAN_WIDTH  = 10;
   localparam int EXP_BIAS   = 15;

   localparam logic [15:0] FP16_QNAN    = 16'h7E00;
   localparam logic [14:0] FP16_INF_MAG = 15'h7C00;

   typedef enum logic [1:0] {
      ZERO,
      NORMAL,
      INF,
      NAN
   } fp_class_t;

   // exp is kept signed so biased sums and under/overflow never wrap
   typedef struct packed {
      logic              sign;
      logic signed [6:0] exp;
      logic [10:0]       man;
      fp_class_t         cls;
   } fp16_unpacked_t;

   // Split a binary16 word; subnormals are classified as zero (flushed)
   function automatic fp16_unpacked_t fp16_unpack(input logic [15:0] x);
      fp16_unpacked_t u;
      logic [4:0]     e;
      e      = x[14:10];
      u.sign = x[15];
      u.exp  = $signed({2'b00, e});
      u.man  = {1'b1, x[9:0]};
      if (e == 5'd0) begin
         u.cls = ZERO;
      end else if (e == 5'h1F) begin
         u.cls = (x[9:0] == 10'd0) ? INF : NAN;
      end else begin
         u.cls = NORMAL;
      end
      return u;
   endfunction

   // Result class of a product, highest-priority special first
   function automatic fp_class_t fp16_mul_class(input fp_class_t ca, input fp_class_t cb);
      fp_class_t c;
      if (ca == NAN || cb == NAN || (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
         c = NAN;
      end else if (ca == INF || cb == INF) begin
         c = INF;
      end else if (ca == ZERO || cb == ZERO) begin
         c = ZERO;
      end else begin
         c = NORMAL;
      end
      return c;
   endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Normalize, round-to-nearest-even and pack a 22-bit 1.x/1x.x mantissa into binary16.
// Purely combinational (zero latency).
// No flow control; the enclosing pipeline stage owns stalls.
module fp16_round_pack
   import fp16_pkg::*;
(
   input  logic              [21:0] man_i,
   input  logic signed       [6:0]  exp_i,
   input  logic                     sign_i,
   input  fp_class_t                cls_i,
   output logic              [15:0] result_o
);

   logic              norm_hi;
   logic [9:0]        frac_t;
   logic              guard;
   logic              rnd;
   logic              sticky;
   logic              round_up;
   logic [10:0]       frac_r;
   logic signed [7:0] exp_n;
   logic signed [7:0] exp_f;

   // Normalize on bit 21, round with guard/round/sticky, then resolve specials
   always_comb begin
      norm_hi  = man_i[21];
      frac_t   = norm_hi ? man_i[20:11] : man_i[19:10];
      guard    = norm_hi ? man_i[10]    : man_i[9];
      rnd      = norm_hi ? man_i[9]     : man_i[8];
      sticky   = norm_hi ? (|man_i[8:0]) : (|man_i[7:0]);
      exp_n    = {exp_i[6], exp_i} + (norm_hi ? 8'sd1 : 8'sd0);
      round_up = guard & (rnd | sticky | frac_t[0]);
      frac_r   = {1'b0, frac_t} + {10'd0, round_up};
      // fraction carry-out means 1.111..1 rounded up to 10.0: fraction wraps to 0
      exp_f    = frac_r[10] ? (exp_n + 8'sd1) : exp_n;

      if (cls_i == NAN) begin
         result_o = FP16_QNAN;
      end else if (cls_i == INF) begin
         result_o = {sign_i, FP16_INF_MAG};
      end else if (cls_i == ZERO) begin
         result_o = {sign_i, 15'h0000};
      end else if (exp_f >= 8'sd31) begin
         result_o = {sign_i, FP16_INF_MAG};
      end else if (exp_f <= 8'sd0) begin
         result_o = {sign_i, 15'h0000};
      end else begin
         result_o = {sign_i, exp_f[4:0], frac_r[9:0]};
      end
   end

endmodule

// File: rtl/floating_point_multiplier.sv
// Pipelined binary16 multiplier feeding the PE accumulator (unpack, multiply, round/pack).
// Latency: 3 register stages; a pair sampled at edge N shows on result after edge N+2.
// en=0 freezes every stage and the outputs; bubbles shift a 0 valid bit through.
module floating_point_multiplier #(
   parameter int DATA_WIDTH = 16,
   parameter int EXP_WIDTH  = 5,
   parameter int MAN_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  valid_out
);

   import fp16_pkg::*;

   localparam int PROD_WIDTH = 2 * (MAN_WIDTH + 1);
   localparam int SEXP_WIDTH = EXP_WIDTH + 2;

   fp16_unpacked_t ua;
   fp16_unpacked_t ub;

   // S1: product sign, biased exponent sum, multiplicand mantissa, combined class
   fp16_unpacked_t         s1_d;
   fp16_unpacked_t         s1_q;
   logic [MAN_WIDTH:0]     s1_manb_d;
   logic [MAN_WIDTH:0]     s1_manb_q;
   logic                   s1_vld_q;

   // S2: raw 22-bit product plus pass-through sign/exponent/class
   logic [PROD_WIDTH-1:0]        s2_man_d;
   logic [PROD_WIDTH-1:0]        s2_man_q;
   logic signed [SEXP_WIDTH-1:0] s2_exp_q;
   logic                         s2_sign_q;
   fp_class_t                    s2_cls_q;
   logic                         s2_vld_q;

   // S3: packed result, only reloaded when a valid product arrives
   logic [DATA_WIDTH-1:0] rp_result;
   logic [DATA_WIDTH-1:0] result_d;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  valid_q;

   // Unpack both operands and form the S1 next state
   always_comb begin
      ua          = fp16_unpack(a);
      ub          = fp16_unpack(b);
      s1_d.sign   = ua.sign ^ ub.sign;
      s1_d.exp    = ua.exp + ub.exp - 7'(EXP_BIAS);
      s1_d.man    = ua.man;
      s1_d.cls    = fp16_mul_class(ua.cls, ub.cls);
      s1_manb_d   = ub.man;
   end

   // S1 register: classify/unpack stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q      <= '0;
         s1_manb_q <= '0;
         s1_vld_q  <= 1'b0;
      end else if (en) begin
         s1_q      <= s1_d;
         s1_manb_q <= s1_manb_d;
         s1_vld_q  <= valid_in;
      end
   end

   // 11x11 unsigned mantissa product
   always_comb begin
      s2_man_d = PROD_WIDTH'(s1_q.man) * PROD_WIDTH'(s1_manb_q);
   end

   // S2 register: multiply stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_man_q  <= '0;
         s2_exp_q  <= '0;
         s2_sign_q <= 1'b0;
         s2_cls_q  <= ZERO;
         s2_vld_q  <= 1'b0;
      end else if (en) begin
         s2_man_q  <= s2_man_d;
         s2_exp_q  <= s1_q.exp;
         s2_sign_q <= s1_q.sign;
         s2_cls_q  <= s1_q.cls;
         s2_vld_q  <= s1_vld_q;
      end
   end

   fp16_round_pack u_round_pack (
      .man_i    (s2_man_q),
      .exp_i    (s2_exp_q),
      .sign_i   (s2_sign_q),
      .cls_i    (s2_cls_q),
      .result_o (rp_result)
   );

   // Keep the last product visible through bubbles
   always_comb begin
      result_d = s2_vld_q ? rp_result : result_q;
   end

   // S3 register: output stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= '0;
         valid_q  <= 1'b0;
      end else if (en) begin
         result_q <= result_d;
         valid_q  <= s2_vld_q;
      end
   end

   assign result    = result_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_floating_point_multiplier.sv
// Directed bench for floating_point_multiplier with a latency-tagged scoreboard.
// Each accepted pair is tagged with the advance count at which it must appear.
// Cycles with nothing due must show valid_out=0, so bubbles and stalls are checked too.
module tb_floating_point_multiplier;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        valid_in;
   logic [15:0] a;
   logic [15:0] b;
   logic [15:0] result;
   logic        valid_out;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] data;
      int          due;
   } sb_t;

   sb_t sb_q[$];

   int adv_cnt  = 0;
   bit adv_last = 1'b0;

   floating_point_multiplier #(
      .DATA_WIDTH (16),
      .EXP_WIDTH  (5),
      .MAN_WIDTH  (10)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .valid_in  (valid_in),
      .a         (a),
      .b         (b),
      .result    (result),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   // Count edges at which the pipe advanced
   always @(posedge clk) begin
      if (en && !reset) adv_cnt <= adv_cnt + 1;
      adv_last <= en && !reset;
   end

   // Scoreboard: the oldest entry must appear exactly at its due advance, else no valid
   always @(negedge clk) begin
      if (!reset) begin
         if (sb_q.size() > 0 && sb_q[0].due == adv_cnt) begin
            total++;
            assert ({valid_out, result} === {1'b1, sb_q[0].data})
            else begin
               bad++;
               $error("FAIL sb_out observed valid=%b result=%h expected valid=1 result=%h",
                      valid_out, result, sb_q[0].data);
            end
            void'(sb_q.pop_front());
         end else if (adv_last) begin
            total++;
            assert (valid_out === 1'b0)
            else begin
               bad++;
               $error("FAIL sb_idle observed valid_out=%b expected 0 (result=%h)", valid_out, result);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      total++;
      assert (obs === exp_v)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Present one pair for one advancing edge; its product is due 3 advances from now
   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ev);
      a        = av;
      b        = bv;
      valid_in = 1'b1;
      sb_q.push_back('{data: ev, due: adv_cnt + 3});
      cyc();
      valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      reset    = 1'b0;
      en       = 1'b1;
      valid_in = 1'b0;
      a        = 16'h0000;
      b        = 16'h0000;
      #1 reset = 1'b1;
      #1;
      chk("rst_valid", {15'd0, valid_out}, 16'h0000);
      chk("rst_result", result, 16'h0000);
      cyc();
      cyc();
      reset = 1'b0;
      idle(2);

      // Reset with three pairs in flight: nothing stale may emerge
      send(16'h4200, 16'h4000, 16'h4600);
      send(16'h4000, 16'h4000, 16'h4400);
      send(16'h3C00, 16'h3C00, 16'h3C00);
      reset = 1'b1;
      #1;
      chk("midrst_valid", {15'd0, valid_out}, 16'h0000);
      chk("midrst_result", result, 16'h0000);
      sb_q.delete();
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("post_rst_valid", {15'd0, valid_out}, 16'h0000);
         chk("post_rst_result", result, 16'h0000);
      end

      // Latency: sampled at edge N, visible after edge N+2
      send(16'h4200, 16'h4000, 16'h4600);
      chk("lat_n0", {15'd0, valid_out}, 16'h0000);
      cyc();
      chk("lat_n1", {15'd0, valid_out}, 16'h0000);
      cyc();
      chk("lat_n2_valid", {15'd0, valid_out}, 16'h0001);
      chk("lat_n2_result", result, 16'h4600);

      // Stall two cycles mid-flight, then stall with a product at the output
      send(16'hC000, 16'h4200, 16'hC600);
      en = 1'b0;
      cyc();
      cyc();
      chk("stall_valid", {15'd0, valid_out}, 16'h0000);
      chk("stall_hold_prev", result, 16'h4600);
      en = 1'b1;
      cyc();
      chk("stall_n3", {15'd0, valid_out}, 16'h0000);
      cyc();
      chk("stall_n4_valid", {15'd0, valid_out}, 16'h0001);
      chk("stall_n4_result", result, 16'hC600);
      en = 1'b0;
      cyc();
      cyc();
      chk("outhold_valid", {15'd0, valid_out}, 16'h0001);
      chk("outhold_result", result, 16'hC600);
      en = 1'b1;
      idle(1);
      chk("bubble_hold_result", result, 16'hC600);

      // Inputs must be ignored while stalled
      en       = 1'b0;
      a        = 16'h4000;
      b        = 16'h4000;
      valid_in = 1'b1;
      cyc();
      cyc();
      valid_in = 1'b0;
      en       = 1'b1;
      idle(4);

      // Normalization, rounding, specials, overflow, underflow (back-to-back)
      send(16'h3E00, 16'h3E00, 16'h4080);
      send(16'h4E00, 16'h0000, 16'h0000);
      send(16'h3C01, 16'h3C01, 16'h3C02);
      send(16'h3C01, 16'h3E00, 16'h3E02);
      send(16'h7C00, 16'h0000, 16'h7E00);
      send(16'h7E00, 16'h3C00, 16'h7E00);
      send(16'hFC00, 16'h4000, 16'hFC00);
      send(16'h7BFF, 16'h4000, 16'h7C00);
      send(16'h0400, 16'h3800, 16'h0000);
      send(16'h0001, 16'h7BFF, 16'h0000);
      idle(4);
      chk("last_result", result, 16'h0000);

      // Eight-pair stream with one bubble after the fourth
      send(16'h3C00, 16'h3C00, 16'h3C00);
      send(16'h4000, 16'h4000, 16'h4400);
      send(16'h4200, 16'h4200, 16'h4880);
      send(16'h3800, 16'h4400, 16'h4000);
      idle(1);
      send(16'hC400, 16'h3800, 16'hC000);
      send(16'h4500, 16'h4000, 16'h4900);
      send(16'h3C00, 16'hBC00, 16'hBC00);
      send(16'h4400, 16'h4400, 16'h4C00);
      idle(5);

      chk("sb_drained", 16'(sb_q.size()), 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
